// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one bit per clock (LSB first), with a start/busy/done handshake.
// Results land in diff/bout only on completion, so the outputs never show a partial value.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             x_bit;
   logic             y_bit;
   logic             d_bit;
   logic             b_next;
   logic [WIDTH-1:0] res_shift;

   always_comb begin
      state_d   = state_q;
      ra_d      = ra_q;
      rb_d      = rb_q;
      res_d     = res_q;
      br_d      = br_q;
      cnt_d     = cnt_q;
      diff_d    = diff_q;
      bout_d    = bout_q;
      busy_d    = busy_q;
      done_d    = done_q;

      // Single full-subtractor cell fed from the low bits of the operand shifters
      x_bit     = ra_q[0];
      y_bit     = rb_q[0];
      d_bit     = x_bit ^ y_bit ^ br_q;
      b_next    = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
      res_shift = {d_bit, res_q[WIDTH-1:1]};

      case (state_q)
         IDLE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               br_d    = bin;
               res_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            ra_d  = ra_q >> 1;
            rb_d  = rb_q >> 1;
            res_d = res_shift;
            br_d  = b_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               diff_d  = res_shift;
               bout_d  = b_next;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         res_q   <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         res_q   <= res_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of serial_subtractor at WIDTH=4 and WIDTH=8.
// Expected {bout, diff} values are queued when an operation is launched and popped on done.
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start4, bin4, bout4, busy4, done4;
   logic [3:0] a4, b4, diff4;
   logic       start8, bin8, bout8, busy8, done8;
   logic [7:0] a8, b8, diff8;

   logic [4:0] q4[$];
   logic [8:0] q8[$];
   logic [4:0] last_exp4;
   int         tests_run   = 0;
   int         tests_failed = 0;
   int         ops4        = 0;
   int         done_cnt4   = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .diff(diff4), .bout(bout4), .busy(busy4), .done(done4)
   );

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
   );

   always @(posedge clk) begin
      if (done4) done_cnt4 <= done_cnt4 + 1;
   end

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pushExpected(input logic [3:0] av, input logic [3:0] bv, input logic biv);
      q4.push_back({1'b0, av} - {1'b0, bv} - 5'(biv));
      ops4++;
   endtask

   task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic biv);
      start4 = 1'b1;
      a4     = av;
      b4     = bv;
      bin4   = biv;
      pushExpected(av, bv, biv);
   endtask

   task automatic scoreDone(input string tag);
      checkValue({tag, "_sb_nonempty"}, 32'(q4.size() > 0), 32'd1);
      if (q4.size() > 0) begin
         last_exp4 = q4.pop_front();
         checkValue(tag, {bout4, diff4}, last_exp4);
      end
   endtask

   task automatic checkOutput();
      int nb = 1;
      int i  = 0;
      @(negedge clk);
      while (!done4 && i < 8) begin
         if (busy4) nb++;
         @(negedge clk);
         i++;
      end
      checkValue("done_seen", done4, 1);
      checkValue("busy_cycles", nb, 4);
      checkValue("busy_at_done", busy4, 0);
      scoreDone("result");
      @(negedge clk);
      checkValue("done_fall", done4, 0);
      checkValue("result_hold", {bout4, diff4}, last_exp4);
   endtask

   task automatic runOp(input logic [3:0] av, input logic [3:0] bv, input logic biv);
      applyStimulus(av, bv, biv);
      @(negedge clk);
      start4 = 1'b0;
      a4     = ~av;
      b4     = ~bv;
      bin4   = ~biv;
      checkValue("busy_after_start", busy4, 1);
      checkOutput();
   endtask

   initial begin
      logic [4:0] dropped;
      logic       saw_done;
      logic [8:0] exp8;
      int         w;

      reset_n = 1'b0;
      start4  = 1'b1;
      a4      = 4'd5;
      b4      = 4'd2;
      bin4    = 1'b0;
      start8  = 1'b0;
      a8      = '0;
      b8      = '0;
      bin8    = 1'b0;

      repeat (2) begin
         @(negedge clk);
         checkValue("reset_outputs", {diff4, bout4, busy4, done4}, 0);
      end
      reset_n = 1'b1;
      runOp(4'd5, 4'd2, 1'b0);

      runOp(4'd7, 4'd3, 1'b0);
      runOp(4'd3, 4'd7, 1'b0);
      runOp(4'd0, 4'd0, 1'b1);
      runOp(4'd15, 4'd15, 1'b1);
      runOp(4'd15, 4'd0, 1'b0);

      // start held high with operands changing every cycle
      for (int c = 0; c < 18; c++) begin
         checkValue("stream_busy_done", {busy4, done4},
                    {((c % 6) >= 1 && (c % 6) <= 4), ((c % 6) == 5)});
         if (done4) scoreDone("stream_result");
         start4 = 1'b1;
         a4     = 4'($urandom);
         b4     = 4'($urandom);
         bin4   = 1'($urandom);
         if (c % 6 == 0) pushExpected(a4, b4, bin4);
         @(negedge clk);
      end
      start4 = 1'b0;
      checkValue("stream_drained", q4.size(), 0);
      @(negedge clk);

      runOp(4'd9, 4'd1, 1'b0);
      applyStimulus(4'd2, 4'd1, 1'b0);
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      checkValue("abort_outputs", {diff4, bout4, busy4, done4}, 0);
      dropped = q4.pop_back();
      ops4--;
      reset_n  = 1'b1;
      saw_done = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done4) saw_done = 1'b1;
      end
      checkValue("abort_no_done", saw_done, 0);
      runOp(4'd12, 4'd5, 1'b1);

      for (int i = 0; i < 512; i++) begin
         runOp(i[3:0], i[7:4], i[8]);
      end

      for (int n = 0; n < 24; n++) begin
         start8 = 1'b1;
         a8     = (n == 0) ? 8'd0 : (n == 1) ? 8'd255 : 8'($urandom);
         b8     = (n == 0) ? 8'd0 : (n == 1) ? 8'd255 : 8'($urandom);
         bin8   = (n < 2) ? 1'b1 : 1'($urandom);
         q8.push_back({1'b0, a8} - {1'b0, b8} - 9'(bin8));
         @(negedge clk);
         start8 = 1'b0;
         a8     = ~a8;
         b8     = ~b8;
         w      = 0;
         while (!done8 && w < 12) begin
            @(negedge clk);
            w++;
         end
         checkValue("w8_done_seen", done8, 1);
         exp8 = q8.pop_front();
         checkValue("w8_result", {bout8, diff8}, exp8);
         @(negedge clk);
      end

      checkValue("done_count", done_cnt4, ops4);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor. It computes a - b - bin one bit per clock, LSB first.
- Built around a single one-bit full subtractor: diff bit = x ^ y ^ br; borrow = (~x & y) | (~(x ^ y) & br).
- Sequential counterpart to the combinational gate-level adder blocks. Trades area for WIDTH cycles of latency.
- Start/busy/done handshake, for use by the serial ALU datapath.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
start  input  1  request; accepted only in IDLE
a  input  WIDTH  minuend, captured on the accepted start
b  input  WIDTH  subtrahend, captured on the accepted start
bin  input  1  initial borrow-in, captured on the accepted start
diff  output  WIDTH  registered difference, valid from the done pulse until the next completion
bout  output  1  registered final borrow-out
busy  output  1  high while bits are being processed
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state <= IDLE.
  - diff, bout, busy, done <= 0.
  - Internal shift registers, borrow flop and bit counter <= 0.
  - Reset has priority over start and over any in-flight operation. Mid-RUN it aborts the operation with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: ra <= a, rb <= b, br <= bin, cnt <= 0, state <= RUN, busy <= 1.
  - start=0: remain in IDLE. All outputs hold.
- RUN, every edge:
  - x = ra[0], y = rb[0].
  - Result shift register shifts right with (x ^ y ^ br) entering at the MSB.
  - ra and rb shift right; br <= borrow(x, y, br); cnt <= cnt + 1.
  - On the edge that processes bit WIDTH-1 (cnt == WIDTH-1):
    - diff <= final result register; bout <= final borrow.
    - busy <= 0, done <= 1, state <= DONE.
- DONE: on the next edge done <= 0 and state <= IDLE, unconditionally. start is ignored in DONE.
- Timing, with start accepted at edge k:
  - busy is high for exactly WIDTH cycles, after edges k .. k+WIDTH-1.
  - diff, bout and done update at edge k+WIDTH. done falls at edge k+WIDTH+1.
  - The earliest next acceptance is edge k+WIDTH+2.
- Function: {bout, diff} == (a - b - bin) mod 2^(WIDTH+1) on the captured operands. bout=1 iff a < b + bin (unsigned).
- diff and bout are never partially updated during RUN. They hold the previous result until completion, or 0 after reset.
- a, b and bin changes after acceptance have no effect. start during RUN or DONE is ignored; no queuing.
- No X propagation: every register has a reset value.

Test Plan:
- Hold reset_n=0 for 2 cycles with start=1, a=5, b=2 -> diff=0, bout=0, busy=0, done=0 throughout. After release, start is accepted on the first edge with reset_n=1.
- a=4'd7, b=4'd3, bin=0, start 1 cycle -> busy high 4 cycles, then done 1 cycle, diff=4'd4, bout=0. diff holds 4 after done falls.
- Borrow corners:
  - a=3, b=7, bin=0 -> diff=4'b1100, bout=1.
  - a=0, b=0, bin=1 -> diff=4'hF, bout=1.
  - a=15, b=15, bin=1 -> diff=4'hF, bout=1.
  - a=15, b=0, bin=0 -> diff=4'hF, bout=0.
- start held high continuously; a/b change every cycle during RUN -> each result matches the operands present at the accepting edge. Acceptances are spaced exactly WIDTH+2 cycles apart; no start taken during RUN or DONE.
- Load a=9, b=1 (diff=8), then start a=2, b=1 and pull reset_n low on RUN cycle 2 -> diff=0, bout=0, busy=0, no done pulse. Next start completes normally.
- Exhaustive sweep: all 512 combinations of a, b, bin at WIDTH=4, plus a random sample at WIDTH=8 -> {bout, diff} matches the reference model on every done pulse; each operation produces exactly one done.
